// File: rtl/spi_seq_pkg.sv
// Shared types and helpers for the SPI sensor command sequencer.
package spi_seq_pkg;

  typedef enum logic [3:0] {
    INIT0,
    WAIT0,
    INIT1,
    WAIT1,
    IDLE,
    RD_LO,
    WAIT_LO,
    RD_HI,
    WAIT_HI,
    PUBLISH
  } seq_state_t;

  localparam logic RD_BIT = 1'b1;

  function automatic logic [15:0] rd_cmd(input logic [6:0] addr);
    return {RD_BIT, addr, 8'h00};
  endfunction

endpackage

// File: rtl/spi_sensor_seq_if.sv
// Command/response handshake between the sequencer and the SPI master.
interface spi_sensor_seq_if;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] spi_rd_data;

  modport master (output wrt, output cmd, input done, input spi_rd_data);
  modport slave  (input wrt, input cmd, output done, output spi_rd_data);
endinterface

// File: rtl/seq_tick_gen.sv
// Free-running sample divider: one-cycle tick every SAMPLE_DIV enabled clocks.
module seq_tick_gen #(
  parameter int unsigned SAMPLE_DIV = 5000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int unsigned CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0] LAST = (SAMPLE_DIV > 0) ? CW'(SAMPLE_DIV - 1) : '0;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_last;

  // A divider of zero never reaches its terminal count.
  assign at_last = (SAMPLE_DIV != 0) && (cnt_q == LAST);
  assign tick    = en && at_last;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (SAMPLE_DIV != 0)) begin
      cnt_d = at_last ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/spi_sensor_seq.sv
// Sequencer ahead of the SPI master: configures the sensor, then reads
// lo/hi sample registers on trigger or timer and publishes 16-bit samples.
module spi_sensor_seq
  import spi_seq_pkg::*;
#(
  parameter logic [15:0] INIT_CMD0  = 16'h0D02,
  parameter logic [15:0] INIT_CMD1  = 16'h1062,
  parameter logic [6:0]  ADDR_LO    = 7'h22,
  parameter logic [6:0]  ADDR_HI    = 7'h23,
  parameter int unsigned SAMPLE_DIV = 5000,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    trig,
  input  logic                    clr_err,
  spi_sensor_seq_if.master        spi,
  output logic                    init_done,
  output logic [15:0]             sample,
  output logic                    sample_vld,
  output logic                    busy,
  output logic                    overrun,
  output logic                    timeout_err
);
  localparam int unsigned WCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  seq_state_t     state_q, state_d;
  logic           wrt_q, wrt_d;
  logic [15:0]    cmd_q, cmd_d;
  logic           init_done_q, init_done_d;
  logic [15:0]    sample_q, sample_d;
  logic           sample_vld_q, sample_vld_d;
  logic           overrun_q, overrun_d;
  logic           timeout_err_q, timeout_err_d;
  logic           pending_q, pending_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [7:0]     lo_q, lo_d, hi_q, hi_d;

  logic tick, req, wait_state, timed_out, ovr_set, tmo_set;
  logic rd_data_unused;

  seq_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (init_done_q),
    .tick (tick)
  );

  assign req        = trig | tick;
  assign wait_state = (state_q == WAIT0) || (state_q == WAIT1) ||
                      (state_q == WAIT_LO) || (state_q == WAIT_HI);
  assign timed_out  = wait_state && !spi.done && (wait_cnt_q == WCW'(TIMEOUT));
  // Only the low byte of each read carries register data.
  assign rd_data_unused = ^spi.spi_rd_data[15:8];

  always_comb begin
    state_d      = state_q;
    wrt_d        = 1'b0;
    cmd_d        = cmd_q;
    init_done_d  = init_done_q;
    sample_d     = sample_q;
    sample_vld_d = 1'b0;
    pending_d    = pending_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    ovr_set      = 1'b0;
    tmo_set      = 1'b0;
    // Entry into a WAIT state always comes from an issue state, so the
    // counter is already zero when a wait begins.
    wait_cnt_d   = wait_state ? wait_cnt_q + WCW'(1) : '0;

    if (req && init_done_q && (state_q != IDLE)) begin
      if (pending_q) ovr_set   = 1'b1;
      else           pending_d = 1'b1;
    end

    case (state_q)
      INIT0: begin
        wrt_d   = 1'b1;
        cmd_d   = INIT_CMD0;
        state_d = WAIT0;
      end
      WAIT0: begin
        if (spi.done) begin
          state_d = INIT1;
        end else if (timed_out) begin
          tmo_set = 1'b1;
          state_d = INIT0;
        end
      end
      INIT1: begin
        wrt_d   = 1'b1;
        cmd_d   = INIT_CMD1;
        state_d = WAIT1;
      end
      WAIT1: begin
        if (spi.done) begin
          init_done_d = 1'b1;
          state_d     = IDLE;
        end else if (timed_out) begin
          tmo_set = 1'b1;
          state_d = INIT0;
        end
      end
      IDLE: begin
        if (req || pending_q) begin
          pending_d = 1'b0;
          state_d   = RD_LO;
        end
      end
      RD_LO: begin
        wrt_d   = 1'b1;
        cmd_d   = rd_cmd(ADDR_LO);
        state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (spi.done) begin
          lo_d    = spi.spi_rd_data[7:0];
          state_d = RD_HI;
        end else if (timed_out) begin
          tmo_set = 1'b1;
          state_d = IDLE;
        end
      end
      RD_HI: begin
        wrt_d   = 1'b1;
        cmd_d   = rd_cmd(ADDR_HI);
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (spi.done) begin
          hi_d    = spi.spi_rd_data[7:0];
          state_d = PUBLISH;
        end else if (timed_out) begin
          tmo_set = 1'b1;
          state_d = IDLE;
        end
      end
      PUBLISH: begin
        sample_d     = {hi_q, lo_q};
        sample_vld_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = INIT0;
    endcase

    overrun_d     = clr_err ? 1'b0 : (overrun_q | ovr_set);
    timeout_err_d = clr_err ? 1'b0 : (timeout_err_q | tmo_set);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= INIT0;
      wrt_q         <= 1'b0;
      cmd_q         <= '0;
      init_done_q   <= 1'b0;
      sample_q      <= '0;
      sample_vld_q  <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      pending_q     <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      wrt_q         <= wrt_d;
      cmd_q         <= cmd_d;
      init_done_q   <= init_done_d;
      sample_q      <= sample_d;
      sample_vld_q  <= sample_vld_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
      pending_q     <= pending_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  // Byte holding registers are pure data; PUBLISH only reads them after a fresh load.
  always_ff @(posedge clk) begin
    lo_q <= lo_d;
    hi_q <= hi_d;
  end

  assign spi.wrt     = wrt_q;
  assign spi.cmd     = cmd_q;
  assign init_done   = init_done_q;
  assign sample      = sample_q;
  assign sample_vld  = sample_vld_q;
  assign busy        = (state_q != IDLE);
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_spi_sensor_seq.sv
// Bench for spi_sensor_seq: trigger-driven instance with a scripted SPI master
// model, plus an auto-timer instance checked for sample period.
module tb_spi_sensor_seq;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst, trig, clr_err;
  logic trig_a, clr_a;
  logic init_done, sample_vld, busy, overrun, timeout_err;
  logic [15:0] sample;
  logic init_done_a, sample_vld_a, busy_a, overrun_a, timeout_err_a;
  logic [15:0] sample_a;

  spi_sensor_seq_if bus ();
  spi_sensor_seq_if bus_a ();

  spi_sensor_seq #(.SAMPLE_DIV(0), .TIMEOUT(1024)) dut (
    .clk(clk), .rst(rst), .trig(trig), .clr_err(clr_err), .spi(bus),
    .init_done(init_done), .sample(sample), .sample_vld(sample_vld),
    .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
  );

  spi_sensor_seq #(.SAMPLE_DIV(100), .TIMEOUT(1024)) dut_a (
    .clk(clk), .rst(rst), .trig(trig_a), .clr_err(clr_a), .spi(bus_a),
    .init_done(init_done_a), .sample(sample_a), .sample_vld(sample_vld_a),
    .busy(busy_a), .overrun(overrun_a), .timeout_err(timeout_err_a)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] cmd_exp[$];
  logic [15:0] smp_exp[$];
  int vld_count = 0;
  bit hold_init = 0, hold_lo = 0, hold_hi = 0;
  logic [7:0] lo_val, lo_up, hi_val, hi_up;
  int a_n = 0;

  typedef struct {
    logic [7:0]  lo;
    logic [7:0]  lo_up;
    logic [7:0]  hi;
    logic [7:0]  hi_up;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // SPI master model for the triggered instance.
  initial begin
    int cyc = 0, m_cnt = 0, nxt_wrt_cyc = 0, hi_done_cyc = 0;
    bit m_busy = 0;
    logic [15:0] m_cmd = '0;
    bit held;
    bus.done = 1'b0;
    bus.spi_rd_data = 16'h0000;
    forever begin
      @(negedge clk);
      cyc++;
      bus.done = 1'b0;
      if (rst) begin
        m_busy = 0;
        nxt_wrt_cyc = 0;
      end else begin
        if (bus.wrt) begin
          if (cmd_exp.size() == 0) begin
            checks++; errors++;
            $display("FAIL cmd_unexpected: got %h, expected no command", bus.cmd);
          end else begin
            check("cmd", 32'(bus.cmd), 32'(cmd_exp.pop_front()));
          end
          if (nxt_wrt_cyc != 0) check("wrt_gap", 32'(cyc), 32'(nxt_wrt_cyc));
          nxt_wrt_cyc = 0;
          m_busy = 1; m_cnt = LAT; m_cmd = bus.cmd;
        end else if (m_busy) begin
          held = (m_cmd[15] == 1'b0) ? hold_init :
                 (m_cmd[14:8] == 7'h22) ? hold_lo : hold_hi;
          if (m_cnt > 1) m_cnt--;
          else if (!held) begin
            bus.done = 1'b1;
            m_busy = 0;
            if (m_cmd[15] == 1'b0) begin
              bus.spi_rd_data = 16'h0000;
              if (m_cmd == 16'h0D02) nxt_wrt_cyc = cyc + 2;
            end else if (m_cmd[14:8] == 7'h22) begin
              bus.spi_rd_data = {lo_up, lo_val};
              nxt_wrt_cyc = cyc + 2;
            end else begin
              bus.spi_rd_data = {hi_up, hi_val};
              hi_done_cyc = cyc;
            end
          end
        end
        if (sample_vld) begin
          vld_count++;
          check("vld_latency", 32'(cyc - hi_done_cyc), 32'd2);
          if (smp_exp.size() == 0) begin
            checks++; errors++;
            $display("FAIL sample_unexpected: got %h, expected no sample", sample);
          end else begin
            check("sample", 32'(sample), 32'(smp_exp.pop_front()));
          end
        end
      end
    end
  end

  // Always-responsive master for the auto-timer instance.
  initial begin
    int a_cyc = 0, a_cnt = 0, a_last = 0;
    bit a_busy = 0;
    logic [15:0] a_cmd = '0;
    bus_a.done = 1'b0;
    bus_a.spi_rd_data = 16'h0000;
    forever begin
      @(negedge clk);
      a_cyc++;
      bus_a.done = 1'b0;
      if (rst) begin
        a_busy = 0;
        a_last = 0;
      end else begin
        if (bus_a.wrt) begin
          a_busy = 1; a_cnt = 2; a_cmd = bus_a.cmd;
        end else if (a_busy) begin
          if (a_cnt > 1) a_cnt--;
          else begin
            bus_a.done = 1'b1;
            bus_a.spi_rd_data = (a_cmd[14:8] == 7'h23) ? 16'hFF12 : 16'hEE34;
            a_busy = 0;
          end
        end
        if (sample_vld_a) begin
          a_n++;
          check("auto_sample", 32'(sample_a), 32'h1234);
          if (a_last != 0) check("auto_period", 32'(a_cyc - a_last), 32'd100);
          a_last = a_cyc;
        end
      end
    end
  end

  task automatic pulse_trig(input logic with_clr);
    trig = 1'b1; clr_err = with_clr;
    @(negedge clk);
    trig = 1'b0; clr_err = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic wait_init(input int bound);
    int n = 0;
    while (!init_done && n < bound) begin @(negedge clk); n++; end
    check("init_wait", 32'(init_done), 32'd1);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy && n < bound) begin @(negedge clk); n++; end
    check("idle_wait", 32'(busy), 32'd0);
  endtask

  task automatic wait_vld(input int target, input int bound);
    int n = 0;
    while (vld_count < target && n < bound) begin @(negedge clk); n++; end
    check("vld_wait", 32'(vld_count), 32'(target));
  endtask

  task automatic wait_tmo(input int bound, output int n);
    n = 0;
    while (!timeout_err && n < bound) begin @(negedge clk); n++; end
    check("tmo_wait", 32'(timeout_err), 32'd1);
  endtask

  task automatic check_reset_outputs();
    check("rst_wrt", 32'(bus.wrt), 32'd0);
    check("rst_cmd", 32'(bus.cmd), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_sample", 32'(sample), 32'd0);
    check("rst_sample_vld", 32'(sample_vld), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
  endtask

  task automatic push_read(input logic [15:0] exp_sample, input bit expect_sample);
    cmd_exp.push_back(16'hA200);
    cmd_exp.push_back(16'hA300);
    if (expect_sample) smp_exp.push_back(exp_sample);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start, n;
    tbl[0] = '{8'hCD, 8'h00, 8'hAB, 8'h00, 16'hABCD};
    tbl[1] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 16'h0000};
    tbl[2] = '{8'hFF, 8'h12, 8'h80, 8'h34, 16'h80FF};
    tbl[3] = '{8'h01, 8'hA5, 8'hFE, 8'h5A, 16'hFE01};
    rst = 1'b1; trig = 1'b0; clr_err = 1'b0; trig_a = 1'b0; clr_a = 1'b0;
    lo_val = 8'h00; lo_up = 8'h00; hi_val = 8'h00; hi_up = 8'h00;

    repeat (3) @(negedge clk);
    check_reset_outputs();
    cmd_exp.push_back(16'h0D02);
    cmd_exp.push_back(16'h1062);
    rst = 1'b0;
    wait_init(100);
    check("init_busy", 32'(busy), 32'd0);
    check("init_cmd_hold", 32'(bus.cmd), 32'h1062);
    check("init_cmds_used", 32'(cmd_exp.size()), 32'd0);

    // Request-to-wrt latency and command hold.
    lo_val = 8'hCD; lo_up = 8'h00; hi_val = 8'hAB; hi_up = 8'h00;
    push_read(16'hABCD, 1);
    start = vld_count;
    pulse_trig(1'b0);
    check("lat_busy", 32'(busy), 32'd1);
    check("lat_wrt_early", 32'(bus.wrt), 32'd0);
    @(negedge clk);
    check("lat_wrt", 32'(bus.wrt), 32'd1);
    check("lat_cmd", 32'(bus.cmd), 32'hA200);
    @(negedge clk);
    check("cmd_hold", 32'(bus.cmd), 32'hA200);
    check("wrt_single", 32'(bus.wrt), 32'd0);
    wait_vld(start + 1, 100);
    wait_idle(20);

    for (int i = 0; i < 4; i++) begin
      lo_val = tbl[i].lo; lo_up = tbl[i].lo_up;
      hi_val = tbl[i].hi; hi_up = tbl[i].hi_up;
      push_read(tbl[i].exp, 1);
      start = vld_count;
      pulse_trig(1'b0);
      wait_vld(start + 1, 100);
      wait_idle(20);
      repeat (3) @(negedge clk);
      check("tbl_sample_out", 32'(sample), 32'(tbl[i].exp));
      check("tbl_vld_once", 32'(vld_count), 32'(start + 1));
    end

    // Three requests during one read: one pending read, then overrun.
    lo_val = 8'h55; hi_val = 8'h66; lo_up = 8'h00; hi_up = 8'h00;
    push_read(16'h6655, 1);
    push_read(16'h6655, 1);
    start = vld_count;
    pulse_trig(1'b0);
    pulse_trig(1'b0);
    check("ovr_first_pending", 32'(overrun), 32'd0);
    pulse_trig(1'b0);
    check("ovr_set", 32'(overrun), 32'd1);
    pulse_trig(1'b0);
    wait_vld(start + 2, 200);
    wait_idle(20);
    repeat (5) @(negedge clk);
    check("ovr_reads", 32'(vld_count), 32'(start + 2));
    check("ovr_sticky", 32'(overrun), 32'd1);
    pulse_clr();
    check("ovr_clr", 32'(overrun), 32'd0);

    // clr_err wins over a same-cycle overrun.
    push_read(16'h6655, 1);
    push_read(16'h6655, 1);
    start = vld_count;
    pulse_trig(1'b0);
    pulse_trig(1'b0);
    pulse_trig(1'b1);
    check("clr_priority", 32'(overrun), 32'd0);
    wait_vld(start + 2, 200);
    wait_idle(20);

    // Withheld HI done: timeout, abandon, sample unchanged.
    hold_hi = 1;
    push_read(16'h0000, 0);
    start = vld_count;
    pulse_trig(1'b0);
    wait_tmo(2000, n);
    check("tmo_window", 32'(n >= 1024 && n <= 1100), 32'd1);
    hold_hi = 0;
    wait_idle(20);
    repeat (5) @(negedge clk);
    check("tmo_no_vld", 32'(vld_count), 32'(start));
    check("tmo_sample_kept", 32'(sample), 32'h6655);
    check("tmo_sticky", 32'(timeout_err), 32'd1);
    pulse_clr();
    check("tmo_clr", 32'(timeout_err), 32'd0);

    // Recovery after an abandoned read.
    lo_val = 8'h22; hi_val = 8'h11;
    push_read(16'h1122, 1);
    start = vld_count;
    pulse_trig(1'b0);
    wait_vld(start + 1, 100);
    wait_idle(20);

    // Reset during WAIT_LO, then a WAIT0 timeout during the replayed init.
    hold_lo = 1;
    cmd_exp.push_back(16'hA200);
    pulse_trig(1'b0);
    repeat (10) @(negedge clk);
    check("wait_lo_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    hold_lo = 0;
    hold_init = 1;
    cmd_exp.push_back(16'h0D02);
    cmd_exp.push_back(16'h0D02);
    cmd_exp.push_back(16'h1062);
    @(negedge clk);
    rst = 1'b0;
    pulse_trig(1'b0);
    pulse_trig(1'b0);
    wait_tmo(2000, n);
    hold_init = 0;
    check("init_tmo_not_done", 32'(init_done), 32'd0);
    check("init_req_ignored", 32'(overrun), 32'd0);
    wait_init(200);
    repeat (3) @(negedge clk);
    check("replay_cmds_used", 32'(cmd_exp.size()), 32'd0);
    check("replay_busy", 32'(busy), 32'd0);
    pulse_clr();
    check("init_tmo_clr", 32'(timeout_err), 32'd0);

    repeat (20) @(negedge clk);
    check("final_cmds", 32'(cmd_exp.size()), 32'd0);
    check("final_samples", 32'(smp_exp.size()), 32'd0);
    check("auto_count", 32'(a_n >= 5), 32'd1);
    check("auto_no_overrun", 32'(overrun_a), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
